// File: rtl/l3l4cs_axis_csum_sink.sv
// l3l4cs_axis_csum_sink
// Downstream AXI-stream slave that computes the 16-bit Internet
// (ones-complement) checksum over the valid bytes of each packet and
// hands one result per packet to the L3/L4 compare logic.
//
// Optional build macro: L3L4CS_CSUM_PIPE_EN
//   defined   -> a register stage sits between beat_sum and the accumulator
//                (result latency 2 cycles after the last-beat handshake)
//   undefined -> result latency 1 cycle after the last-beat handshake
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holds valid and its payload
// stable until that transfer; the result port holds res_valid and all res_*
// payload stable until res_ready is seen. s_tready may depend on s_tvalid
// and s_tlast (a last beat is held back while the result register is busy).

module l3l4cs_axis_csum_sink #(
  parameter int DWIDTH = 76,
  parameter int UWIDTH = 1,
  parameter int BYTES  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic [UWIDTH-1:0] s_tuser,
  input  logic [DWIDTH-1:0] s_tdata,
  output logic              s_tready,
  output logic              s_tuser_slv,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_csum,
  output logic [15:0]       res_len,
  output logic [UWIDTH-1:0] res_user,
  output logic              res_err,
  output logic              dbg_state
);

  localparam int WORDS = BYTES / 2;
  localparam int SW    = 16 + $clog2(WORDS);
  localparam int PW    = $clog2(BYTES + 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t state_q, state_next;

  // Split the stream word into data lanes and keep bits.
  logic [8*BYTES-1:0] data_l;
  logic [BYTES-1:0]   keep;
  logic [BYTES-1:0]   keep_inc;
  assign data_l   = s_tdata[8*BYTES-1:0];
  assign keep     = s_tdata[9*BYTES-1:8*BYTES];
  assign keep_inc = keep + BYTES'(1);

  // Bits above the keep field carry nothing for this block.
  generate
    if (DWIDTH > 9*BYTES) begin : g_spare
      logic unused_spare;
      assign unused_spare = &{1'b0, s_tdata[DWIDTH-1:9*BYTES]};
    end
  endgenerate

  // Ones-complement add of a beat sum into a 16-bit accumulator.
  function automatic logic [15:0] add_fold(input logic [15:0] a,
                                           input logic [SW-1:0] b);
    logic [31:0] t;
    logic [16:0] f1;
    logic [15:0] f2;
    t  = 32'(a) + 32'(b);
    f1 = 17'(t[15:0]) + 17'(t[31:16]);
    f2 = f1[15:0] + 16'(f1[16]);
    return f2;
  endfunction

  // Per-packet state at the accept stage.
  logic [15:0]       acc_q;
  logic [15:0]       len_q;
  logic              err_q;
  logic [UWIDTH-1:0] user_q;
  logic              first_q;

  // Beat-level combinational values.
  logic [8*BYTES-1:0] masked;
  logic [SW-1:0]      beat_sum;
  logic [PW-1:0]      pop;
  logic               keep_full;
  logic               keep_contig;
  logic               beat_err;
  logic [16:0]        len_sum;
  logic [15:0]        len_next;
  logic               err_next;
  logic [UWIDTH-1:0]  user_cur;
  logic               beat_fire;
  logic               stall;

  // Mask disabled lanes, pair lanes into words and count kept bytes.
  always_comb begin
    masked   = '0;
    beat_sum = '0;
    pop      = '0;
    for (int k = 0; k < BYTES; k++) begin
      masked[8*k +: 8] = keep[k] ? data_l[8*k +: 8] : 8'h00;
      pop              = pop + PW'(keep[k]);
    end
    for (int j = 0; j < WORDS; j++) begin
      beat_sum = beat_sum + SW'({masked[16*j +: 8], masked[16*j+8 +: 8]});
    end
  end

  // Keep rules, saturating length and first-beat user selection.
  always_comb begin
    keep_full   = &keep;
    keep_contig = (keep != '0) && ((keep & keep_inc) == '0);
    beat_err    = s_tlast ? !keep_contig : !keep_full;
    len_sum     = {1'b0, len_q} + 17'(pop);
    len_next    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    err_next    = err_q | beat_err;
    user_cur    = first_q ? s_tuser : user_q;
  end

  // Accumulator feed: either straight from this beat or from the pipe stage.
  logic              acc_in_valid;
  logic              acc_in_last;
  logic [SW-1:0]     acc_in_sum;
  logic [15:0]       load_len;
  logic              load_err;
  logic [UWIDTH-1:0] load_user;
  logic              inflight;
  logic [15:0]       acc_add;

`ifdef L3L4CS_CSUM_PIPE_EN
  logic              p_valid;
  logic              p_last;
  logic [SW-1:0]     p_sum;
  logic [15:0]       p_len;
  logic              p_err;
  logic [UWIDTH-1:0] p_user;

  // Timing stage: carries the beat sum plus the finished packet metadata.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_sum   <= '0;
      p_len   <= '0;
      p_err   <= 1'b0;
      p_user  <= '0;
    end else begin
      p_valid <= beat_fire;
      if (beat_fire) begin
        p_last <= s_tlast;
        p_sum  <= beat_sum;
        p_len  <= len_next;
        p_err  <= err_next;
        p_user <= user_cur;
      end
    end
  end

  assign acc_in_valid = p_valid;
  assign acc_in_last  = p_last;
  assign acc_in_sum   = p_sum;
  assign load_len     = p_len;
  assign load_err     = p_err;
  assign load_user    = p_user;
  assign inflight     = p_valid && p_last;
`else
  assign acc_in_valid = beat_fire;
  assign acc_in_last  = s_tlast;
  assign acc_in_sum   = beat_sum;
  assign load_len     = len_next;
  assign load_err     = err_next;
  assign load_user    = user_cur;
  assign inflight     = 1'b0;
`endif

  assign acc_add = add_fold(acc_q, acc_in_sum);

  // A last beat waits while a result would have nowhere to land.
  assign stall     = s_tvalid && s_tlast && ((res_valid && !res_ready) || inflight);
  assign beat_fire = s_tvalid && s_tready;

  // FSM next state and ready: hold a stalled last beat, otherwise accept.
  always_comb begin
    state_next = ST_ACCUM;
    s_tready   = 1'b0;
    if (!reset) begin
      s_tready   = !stall;
      state_next = stall ? ST_HOLD : ST_ACCUM;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_ACCUM;
    else       state_q <= state_next;
  end

  assign dbg_state = state_q;

  // Length, error and user tracking; cleared when the last beat is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      err_q   <= 1'b0;
      user_q  <= '0;
      first_q <= 1'b1;
    end else if (beat_fire) begin
      if (s_tlast) begin
        len_q   <= '0;
        err_q   <= 1'b0;
        first_q <= 1'b1;
      end else begin
        len_q   <= len_next;
        err_q   <= err_next;
        user_q  <= user_cur;
        first_q <= 1'b0;
      end
    end
  end

  // Ones-complement accumulator; restarts at zero after the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (acc_in_valid) begin
      acc_q <= acc_in_last ? 16'h0000 : acc_add;
    end
  end

  // Single-entry result register; a load in a draining cycle replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_csum  <= '0;
      res_len   <= '0;
      res_user  <= '0;
      res_err   <= 1'b0;
    end else if (acc_in_valid && acc_in_last) begin
      res_valid <= 1'b1;
      res_csum  <= ~acc_add;
      res_len   <= load_len;
      res_user  <= load_user;
      res_err   <= load_err;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign s_tuser_slv = res_valid;

endmodule

// File: doc/l3l4cs_axis_csum_sink.md
Name: l3l4cs_axis_csum_sink

Overview:
- Downstream slave stage on the l3l4cs AXI-stream interface, attached to its slave_ports view.
- Consumes packets (tvalid/tready/tlast/tuser/tdata) and computes the 16-bit Internet (ones-complement) checksum over each packet's valid bytes.
- Emits one result per packet on a valid/ready result port, which feeds the L3/L4 checksum compare logic.

Parameters:
- DWIDTH, 76, stream tdata width. Layout: [8*BYTES-1:0] data lanes, [9*BYTES-1:8*BYTES] byte keep, remaining bits ignored.
- UWIDTH, 1, tuser width; the first-beat value is carried to the result.
- BYTES, 8, data lanes per beat. Must be even, with 9*BYTES <= DWIDTH.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- s_tvalid  in  1  stream beat valid.
- s_tlast  in  1  last beat of packet.
- s_tuser  in  UWIDTH  packet sideband, sampled on first beat.
- s_tdata  in  DWIDTH  data + keep, layout as above.
- s_tready  out  1  beat accepted when s_tvalid&&s_tready.
- s_tuser_slv  out  1  result-pending flag (result register full).
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid&&res_ready.
- res_csum  out  16  ~(ones-complement sum of packet words).
- res_len  out  16  packet byte count, saturating at 0xFFFF.
- res_user  out  UWIDTH  s_tuser of the packet's first beat.
- res_err  out  1  keep-rule violation seen in the packet.

Behaviour:
- Reset (synchronous, active-high): s_tready=0 during reset and 1 the cycle after. res_valid=0; res_csum, res_len, res_user, res_err = 0; s_tuser_slv=0; FSM to ACCUM with accumulator, length and error cleared.
- Byte lane k = tdata[8k+7:8k], keep bit k. Words pair lanes (2j, 2j+1) as {lane2j, lane2j+1}. Bytes with keep=0 contribute 0x00.
- Per beat: beat_sum = sum of BYTES/2 words (18 bits for BYTES=8). acc_next = fold(fold(acc + beat_sum)), where fold(x) = x[15:0] + x[31:16]. The accumulator is always 16 bits with end-around carry.
- Length: on every accepted beat, len += popcount(keep), saturating at 0xFFFF.
- Keep rules:
  - Non-last beats must have keep all-ones.
  - Last beat keep must be contiguous from lane 0 and non-zero.
  - A violation sets a sticky err for that packet; the data is still summed as masked.
- tuser is captured on the first beat of each packet.
- FSM states:
  - ACCUM: s_tready=1, except on a beat with s_tlast=1 while the result register is full and not being drained that same cycle. That beat is held (s_tready=0) until res_ready frees the register.
  - On the accepted last beat, the result register loads next cycle: res_valid=1, res_csum=~acc_final, len/user/err latched. Per-packet state clears and the next beat starts a new packet with no bubble.
- Latency: res_valid rises 1 cycle after the last-beat handshake.
- Result register is single-entry. res_valid holds, and its outputs stay stable, until res_ready. Simultaneous drain and load in the same cycle: the new result replaces the old one with no gap.
- s_tuser_slv mirrors res_valid.
- Edge cases:
  - A single-beat packet (first = last) is fully supported.
  - An all-zero packet gives res_csum=0xFFFF.
  - A sum of 0xFFFF gives res_csum=0x0000 (no ±0 normalisation).
- Reset mid-packet discards the partial packet and any pending result.
- s_tdata bits above 9*BYTES are ignored.

Optional Feature:
- Macro L3L4CS_CSUM_PIPE_EN.
- When defined: a register stage is inserted between beat_sum and the accumulator for timing. Result latency becomes 2 cycles after the last-beat handshake. The stall condition still uses result-register occupancy, plus the in-flight pipeline bit, so no result is ever lost. Throughput stays one beat per cycle.
- When undefined: latency is 1 cycle, as specified above.

Test Plan:
- Single beat, lanes 45 00 00 1c 40 00 00 00, keep=0xFF, tlast=1, tuser=1 -> res_csum=0x7AE3, res_len=8, res_user=1, res_err=0, one cycle after the handshake.
- One-byte packet 0xAB, keep=0x01 -> word 0xAB00, res_csum=0x54FF, res_len=1.
- Two beats of all 0xFF bytes, keep=0xFF -> carry folding gives sum 0xFFFF, res_csum=0x0000, res_len=16.
- res_ready held 0, then two back-to-back packets -> second last beat stalled (s_tready=0, s_tuser_slv=1) until res_ready pulses. Both results are delivered in order, with no beat lost.
- Non-last beat with keep=0x0F -> res_err=1 for that packet only; the next packet reports res_err=0.
- reset asserted for 1 cycle mid-packet -> no result emitted. A following 8-byte packet yields the correct checksum and length, unaffected by the partial packet.
